// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_arbiter
// Function : Zero-fills the register file after reset, then arbitrates ALU (A)
//            and load (B) writebacks round-robin onto the registered write port.
// Option   : REGFILE_BYPASS_EN adds write-to-read forwarding on two read ports.
// Revision : 1.0
// ============================================================================
module regfile_wr_arbiter #(
   parameter int NUM_REGS = 32,
   parameter int AW       = 5,
   parameter int DW       = 32
) (
   input  logic          clk,
   input  logic          rst_n,
`ifdef REGFILE_BYPASS_EN
   input  logic [AW-1:0] raddr1,
   input  logic [AW-1:0] raddr2,
   input  logic [DW-1:0] rf_dout1,
   input  logic [DW-1:0] rf_dout2,
   output logic [DW-1:0] fwd_dout1,
   output logic [DW-1:0] fwd_dout2,
`endif
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic          wr,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] din,
   output logic          init_done
);

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic          C_RR_A     = 1'b0;
   localparam logic          C_RR_B     = 1'b1;
   localparam logic [AW:0]   C_LAST_CNT = (AW + 1)'(NUM_REGS - 1);

   state_t          state_q, state_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            rr_q, rr_d;
   logic            wr_q, wr_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [DW-1:0]   din_q, din_d;
   logic            init_done_q, init_done_d;

   logic            grant_a, grant_b;
   logic            hs_a, hs_b;

   // Ready is also gated by rst_n so no handshake can complete on a reset edge.
   assign grant_a = a_valid && (!b_valid || (rr_q == C_RR_A));
   assign grant_b = b_valid && (!a_valid || (rr_q == C_RR_B));
   assign a_ready = rst_n && (state_q == S_RUN) && grant_a;
   assign b_ready = rst_n && (state_q == S_RUN) && grant_b;
   assign hs_a    = a_valid && a_ready;
   assign hs_b    = b_valid && b_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_d        = rr_q;
      wr_d        = 1'b0;
      waddr_d     = waddr_q;
      din_d       = din_q;
      init_done_d = init_done_q;
      unique case (state_q)
         S_INIT: begin
            wr_d    = 1'b1;
            waddr_d = cnt_q[AW-1:0];
            din_d   = '0;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == C_LAST_CNT) begin
               state_d     = S_RUN;
               init_done_d = 1'b1;
            end
         end
         S_RUN: begin
            if (hs_a) begin
               wr_d    = (a_addr != '0);
               waddr_d = a_addr;
               din_d   = a_data;
               rr_d    = C_RR_B;
            end else if (hs_b) begin
               wr_d    = (b_addr != '0);
               waddr_d = b_addr;
               din_d   = b_data;
               rr_d    = C_RR_A;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         rr_q        <= C_RR_A;
         wr_q        <= 1'b0;
         waddr_q     <= '0;
         din_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_q        <= rr_d;
         wr_q        <= wr_d;
         waddr_q     <= waddr_d;
         din_q       <= din_d;
         init_done_q <= init_done_d;
      end
   end

   assign wr        = wr_q;
   assign waddr     = waddr_q;
   assign din       = din_q;
   assign init_done = init_done_q;

`ifdef REGFILE_BYPASS_EN
   // Covers the cycle between a write appearing on the port and its commit.
   assign fwd_dout1 = (wr_q && (waddr_q == raddr1) && (raddr1 != '0)) ? din_q : rf_dout1;
   assign fwd_dout2 = (wr_q && (waddr_q == raddr2) && (raddr2 != '0)) ? din_q : rf_dout2;
`endif

endmodule
`default_nettype wire
